// File: rtl/fpu_conv_arb.sv
// Two-requester round-robin front end for a fixed-latency conversion unit.
// Credit-limited issue, a LAT-deep tag tracker and a 2-entry response FIFO per requester.

module fpu_conv_arb_lane #(
    parameter int TAGW = 5
) (
    input  logic            sys_clk,
    input  logic            rstn,
    input  logic            grant,
    input  logic            retire,
    input  logic            push,
    input  logic [31:0]     push_y,
    input  logic [TAGW-1:0] push_tag,
    input  logic            rsp_ready,
    output logic            credit_ok,
    output logic            rsp_valid,
    output logic [31:0]     rsp_y,
    output logic [TAGW-1:0] rsp_tag,
    output logic            active
);
    logic [1:0]      cnt;
    logic [1:0]      inflight;
    logic [31:0]     y0, y1;
    logic [TAGW-1:0] t0, t1;
    logic            pop;

    assign rsp_valid = (cnt != 2'd0);
    assign pop       = rsp_valid & rsp_ready;
    // Credit counts only registered occupancy; a pop this cycle frees space next cycle.
    assign credit_ok = ({1'b0, cnt} + {1'b0, inflight}) < 3'd2;
    assign rsp_y     = rsp_valid ? y0 : 32'd0;
    assign rsp_tag   = rsp_valid ? t0 : '0;
    assign active    = (cnt != 2'd0) || (inflight != 2'd0);

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            cnt      <= 2'd0;
            inflight <= 2'd0;
            y0       <= 32'd0;
            y1       <= 32'd0;
            t0       <= '0;
            t1       <= '0;
        end else begin
            case ({grant, retire})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase

            if (push && pop) begin
                if (cnt == 2'd2) begin
                    y0 <= y1;
                    t0 <= t1;
                    y1 <= push_y;
                    t1 <= push_tag;
                end else begin
                    y0 <= push_y;
                    t0 <= push_tag;
                end
            end else if (pop) begin
                y0  <= y1;
                t0  <= t1;
                cnt <= cnt - 2'd1;
            end else if (push) begin
                if (cnt == 2'd0) begin
                    y0 <= push_y;
                    t0 <= push_tag;
                end else begin
                    y1 <= push_y;
                    t1 <= push_tag;
                end
                cnt <= cnt + 2'd1;
            end
        end
    end
endmodule

module fpu_conv_arb #(
    parameter int LAT  = 1,
    parameter int TAGW = 5
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [63:0]       req_x,
    input  logic [2*TAGW-1:0] req_tag,
    output logic              unit_valid,
    output logic [31:0]       unit_x,
    input  logic [31:0]       unit_y,
    input  logic              unit_out_valid,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [63:0]       rsp_y,
    output logic [2*TAGW-1:0] rsp_tag,
    output logic              busy,
    output logic              err
);
    logic [1:0]                credit_ok, elig, gnt, retire, push, active;
    logic                      rr, gsel, any_g;
    logic [TAGW-1:0]           gtag;
    logic [LAT:1]              vld_pipe;
    logic [LAT:1]              id_pipe;
    logic [LAT:1][TAGW-1:0]    tag_pipe;

    // Grants are suppressed while in reset so req_ready/unit_valid stay low.
    always_comb begin
        elig  = req_valid & credit_ok & {2{rstn}};
        any_g = |elig;
        gsel  = (elig == 2'b11) ? rr : elig[1];
        gnt   = any_g ? (2'b01 << gsel) : 2'b00;
        gtag  = req_tag[TAGW*gsel +: TAGW];
    end

    assign req_ready  = gnt;
    assign unit_valid = any_g;
    assign unit_x     = any_g ? req_x[32*gsel +: 32] : 32'd0;
    assign busy       = |active;

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            tag_pipe <= '0;
            rr       <= 1'b0;
            err      <= 1'b0;
        end else begin
            vld_pipe[1] <= any_g;
            id_pipe[1]  <= gsel;
            tag_pipe[1] <= gtag;
            for (int k = 2; k <= LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                id_pipe[k]  <= id_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
            if (any_g)
                rr <= ~gsel;
            if (unit_out_valid != vld_pipe[LAT])
                err <= 1'b1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_lane
        // A tracked op always retires its credit, even if the unit dropped its result.
        assign retire[i] = vld_pipe[LAT] && (id_pipe[LAT] == 1'(i));
        assign push[i]   = retire[i] && unit_out_valid;

        fpu_conv_arb_lane #(.TAGW(TAGW)) u_lane (
            .sys_clk   (sys_clk),
            .rstn      (rstn),
            .grant     (gnt[i]),
            .retire    (retire[i]),
            .push      (push[i]),
            .push_y    (unit_y),
            .push_tag  (tag_pipe[LAT]),
            .rsp_ready (rsp_ready[i]),
            .credit_ok (credit_ok[i]),
            .rsp_valid (rsp_valid[i]),
            .rsp_y     (rsp_y[32*i +: 32]),
            .rsp_tag   (rsp_tag[TAGW*i +: TAGW]),
            .active    (active[i])
        );
    end
endmodule
